fnd_scan_sched: RTL and testbench

//  Scan scheduler for the 6-digit common-node 7-segment display. Holds a double-buffered

---
 rtl/fnd_pkg.sv | 39 +++
 rtl/fnd_slot_timer.sv | 48 ++++
 rtl/fnd_scan_sched.sv | 194 +++++++++++++++++++
 tb/tb_fnd_scan_sched.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fnd_pkg.sv
// Shared definitions for the 7-segment display scan path.
//  - NUM_DIGIT / DIG_W : digits per frame and width of a digit index
//  - SEG_BLANK / ENB_ALL_OFF : idle drive values for segments and digit enables
//  - scan_state_e : per-slot FSM states (BLANK guard, ON, OFF)
//  - digit_rec_t  : one stored digit {dp, seg[6:0]}
//  - enb_for_digit: active-low enable vector selecting a single digit
//  - calc_on_len  : PWM ON length from brightness, computed at full width
package fnd_pkg;

  localparam int NUM_DIGIT = 6;
  localparam int DIG_W     = 3;

  localparam logic [6:0] SEG_BLANK   = 7'b0000000;
  localparam logic [5:0] ENB_ALL_OFF = 6'b111111;

  typedef enum logic [1:0] {
    ST_BLANK = 2'd0,
    ST_ON    = 2'd1,
    ST_OFF   = 2'd2
  } scan_state_e;

  typedef struct packed {
    logic       dp;
    logic [6:0] seg;
  } digit_rec_t;

  // Active-low enable with only bit `dig` pulled low.
  function automatic logic [5:0] enb_for_digit(input logic [2:0] dig);
    return ENB_ALL_OFF & ~(6'b000001 << dig);
  endfunction

  // ((bright+1) * span) >> 4; the product is formed in 64 bits so no
  // intermediate overflow is possible for any legal slot length.
  function automatic logic [31:0] calc_on_len(input logic [3:0] bright,
                                              input logic [31:0] span);
    return 32'((({60'd0, bright} + 64'd1) * {32'd0, span}) >> 4);
  endfunction

endpackage

// File: rtl/fnd_slot_timer.sv
// Slot/digit timebase for the display scan.
//  clk, rst_n  : clock and asynchronous active-low reset
//  slot_cnt    : position inside the current digit slot, 0..SLOT_CYC-1
//  digit       : digit being scanned, 0..NUM_DIGIT-1
//  slot_start  : high while slot_cnt == 0
//  slot_wrap   : high on the last cycle of a slot
//  frame_end   : high on the last cycle of the last digit's slot
module fnd_slot_timer
  import fnd_pkg::*;
#(
  parameter int SLOT_CYC = 50000,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [CNT_W-1:0] slot_cnt,
  output logic [2:0]       digit,
  output logic             slot_start,
  output logic             slot_wrap,
  output logic             frame_end
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SLOT_CYC - 1);
  localparam logic [2:0]       DIG_LAST = 3'(NUM_DIGIT - 1);

  logic [CNT_W-1:0] slot_cnt_r;
  logic [2:0]       digit_r;

  // Slot counter wraps every SLOT_CYC cycles; digit index advances on the wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_cnt_r <= '0;
      digit_r    <= 3'd0;
    end else if (slot_wrap) begin
      slot_cnt_r <= '0;
      digit_r    <= (digit_r == DIG_LAST) ? 3'd0 : digit_r + 3'd1;
    end else begin
      slot_cnt_r <= slot_cnt_r + CNT_W'(1);
    end
  end

  assign slot_cnt   = slot_cnt_r;
  assign digit      = digit_r;
  assign slot_start = (slot_cnt_r == '0);
  assign slot_wrap  = (slot_cnt_r == CNT_LAST);
  assign frame_end  = slot_wrap && (digit_r == DIG_LAST);

endmodule

// File: rtl/fnd_scan_sched.sv
// Scan scheduler for a 6-digit common-node 7-segment display.
// Digit writes land in a shadow buffer; a commit request copies the shadow
// into the active (displayed) buffer at the next frame end, so a frame is
// never torn. Each digit slot starts with a blank guard, then a PWM ON
// window whose length follows the 4-bit brightness, then OFF.
//  clk, rst_n     : clock, asynchronous active-low reset
//  i_wr_valid     : write request for shadow[i_wr_addr]
//  o_wr_ready     : low while a commit is pending (shadow frozen)
//  i_wr_addr      : digit index; indices >= NUM_DIGIT are accepted and dropped
//  i_wr_seg/dp    : segment pattern {a..g} and decimal point, 1 = lit
//  i_commit       : pulse requesting shadow -> active copy at next frame end
//  i_bright       : brightness 0..15, sampled at each slot start
//  o_commit_done  : pulse in the first cycle the new active buffer is in effect
//  o_seg/o_seg_dp : segment drive; o_seg_enb: active-low digit enables
// GUARD_CYC is expected to be at least 1 and below SLOT_CYC.
module fnd_scan_sched
  import fnd_pkg::*;
#(
  parameter int SLOT_CYC  = 50000,
  parameter int GUARD_CYC = 500
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_wr_valid,
  output logic       o_wr_ready,
  input  logic [2:0] i_wr_addr,
  input  logic [6:0] i_wr_seg,
  input  logic       i_wr_dp,
  input  logic       i_commit,
  input  logic [3:0] i_bright,
  output logic       o_commit_done,
  output logic [6:0] o_seg,
  output logic       o_seg_dp,
  output logic [5:0] o_seg_enb
);

  localparam int          CNT_W      = (SLOT_CYC > 1) ? $clog2(SLOT_CYC) : 1;
  localparam int unsigned ON_SPAN    = SLOT_CYC - GUARD_CYC;
  localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_CYC - 1);
  localparam logic [CNT_W:0]   GUARD_EXT  = (CNT_W + 1)'(GUARD_CYC);

  // Timebase
  logic [CNT_W-1:0] slot_cnt_s;
  logic [2:0]       digit_s;
  logic             slot_start_s;
  logic             slot_wrap_s;
  logic             frame_end_s;

  // PWM / FSM
  scan_state_e      state_r;
  logic [CNT_W:0]   on_len_r;
  logic [CNT_W:0]   on_len_new_s;
  logic [CNT_W:0]   on_len_now_s;
  logic [CNT_W:0]   on_last_s;

  // Buffers and handshake
  digit_rec_t       shadow_r [NUM_DIGIT];
  digit_rec_t       active_r [NUM_DIGIT];
  logic             commit_pend_r;
  logic             wr_ready_r;
  logic             commit_done_r;
  logic             wr_fire_s;
  logic             wr_addr_ok_s;

  // Output registers
  logic [6:0]       seg_r;
  logic             seg_dp_r;
  logic [5:0]       seg_enb_r;

  fnd_slot_timer #(
    .SLOT_CYC (SLOT_CYC),
    .CNT_W    (CNT_W)
  ) u_slot_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .slot_cnt   (slot_cnt_s),
    .digit      (digit_s),
    .slot_start (slot_start_s),
    .slot_wrap  (slot_wrap_s),
    .frame_end  (frame_end_s)
  );

  // ON-window length: fresh value during the slot-start cycle, latched value after.
  always_comb begin
    on_len_new_s = (CNT_W + 1)'(calc_on_len(i_bright, ON_SPAN));
    if (slot_start_s) begin
      on_len_now_s = on_len_new_s;
    end else begin
      on_len_now_s = on_len_r;
    end
    // Last slot_cnt value that is still ON; only consulted while in ON (on_len_r >= 1).
    on_last_s = GUARD_EXT + on_len_r - (CNT_W + 1)'(1);
  end

  // Per-slot FSM: BLANK guard, then ON for on_len cycles, then OFF; every wrap restarts BLANK.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= ST_BLANK;
      on_len_r <= '0;
    end else begin
      if (slot_start_s) begin
        on_len_r <= on_len_new_s;
      end
      if (slot_wrap_s) begin
        state_r <= ST_BLANK;
      end else begin
        case (state_r)
          ST_BLANK: begin
            if (slot_cnt_s == GUARD_LAST) begin
              state_r <= (on_len_now_s != '0) ? ST_ON : ST_OFF;
            end
          end
          ST_ON: begin
            if ({1'b0, slot_cnt_s} == on_last_s) begin
              state_r <= ST_OFF;
            end
          end
          ST_OFF: begin
            state_r <= ST_OFF;
          end
          default: begin
            state_r <= ST_BLANK;
          end
        endcase
      end
    end
  end

  // Write handshake decode.
  always_comb begin
    wr_fire_s    = i_wr_valid && wr_ready_r;
    wr_addr_ok_s = (i_wr_addr < 3'(NUM_DIGIT));
  end

  // Shadow buffer: accepted writes to out-of-range indices are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_DIGIT; k++) begin
        shadow_r[k] <= '0;
      end
    end else if (wr_fire_s && wr_addr_ok_s) begin
      shadow_r[i_wr_addr] <= '{dp: i_wr_dp, seg: i_wr_seg};
    end
  end

  // Commit tracking and the frame-end copy; a request while pending is ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      commit_pend_r <= 1'b0;
      wr_ready_r    <= 1'b1;
      commit_done_r <= 1'b0;
      for (int k = 0; k < NUM_DIGIT; k++) begin
        active_r[k] <= '0;
      end
    end else if (frame_end_s && commit_pend_r) begin
      for (int k = 0; k < NUM_DIGIT; k++) begin
        active_r[k] <= shadow_r[k];
      end
      commit_pend_r <= 1'b0;
      wr_ready_r    <= 1'b1;
      commit_done_r <= 1'b1;
    end else if (i_commit && !commit_pend_r) begin
      commit_pend_r <= 1'b1;
      wr_ready_r    <= 1'b0;
      commit_done_r <= 1'b0;
    end else begin
      commit_done_r <= 1'b0;
    end
  end

  // Pin registers: drive the selected digit only while the FSM is in ON.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_r     <= SEG_BLANK;
      seg_dp_r  <= 1'b0;
      seg_enb_r <= ENB_ALL_OFF;
    end else if (state_r == ST_ON) begin
      seg_r     <= active_r[digit_s].seg;
      seg_dp_r  <= active_r[digit_s].dp;
      seg_enb_r <= enb_for_digit(digit_s);
    end else begin
      seg_r     <= SEG_BLANK;
      seg_dp_r  <= 1'b0;
      seg_enb_r <= ENB_ALL_OFF;
    end
  end

  assign o_seg         = seg_r;
  assign o_seg_dp      = seg_dp_r;
  assign o_seg_enb     = seg_enb_r;
  assign o_wr_ready    = wr_ready_r;
  assign o_commit_done = commit_done_r;

endmodule

// File: tb/tb_fnd_scan_sched.sv
// Self-checking bench for fnd_scan_sched with SLOT_CYC=40, GUARD_CYC=8.
// A cycle model computes the expected pins for each clock; the expectation is
// queued when the inputs are driven and popped when the pins are sampled on
// the following falling edge. A phase table and hand sequences add targeted
// checks (done-pulse counts, lit-cycle counts, reset behaviour).
module tb_fnd_scan_sched;

  localparam int S = 40;
  localparam int G = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       i_wr_valid = 1'b0;
  logic       o_wr_ready;
  logic [2:0] i_wr_addr = 3'd0;
  logic [6:0] i_wr_seg = 7'd0;
  logic       i_wr_dp = 1'b0;
  logic       i_commit = 1'b0;
  logic [3:0] i_bright = 4'd0;
  logic       o_commit_done;
  logic [6:0] o_seg;
  logic       o_seg_dp;
  logic [5:0] o_seg_enb;

  fnd_scan_sched #(.SLOT_CYC(S), .GUARD_CYC(G)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_wr_valid(i_wr_valid), .o_wr_ready(o_wr_ready),
    .i_wr_addr(i_wr_addr), .i_wr_seg(i_wr_seg), .i_wr_dp(i_wr_dp),
    .i_commit(i_commit), .i_bright(i_bright),
    .o_commit_done(o_commit_done),
    .o_seg(o_seg), .o_seg_dp(o_seg_dp), .o_seg_enb(o_seg_enb)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0] enb;
    logic [6:0] seg;
    logic       dp;
    logic       rdy;
    logic       done;
  } exp_t;

  typedef struct {
    bit         wv;
    logic [2:0] addr;
    logic [6:0] seg;
    bit         dp;
    bit         cm;
    logic [3:0] br;
    int         exp_done;
    int         exp_hits;
  } row_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;

  // model state (value before the next clock edge)
  int         m_cnt, m_dig, m_onlen;
  bit         m_pend, m_fired;
  logic [7:0] m_act [6];
  logic [7:0] m_shd [6];

  // observation counters
  int         done_seen, pat_hits, lit_any;
  int         lit_seen [6];
  logic [5:0] pat_enb;
  logic [6:0] pat_seg;
  logic       pat_dp;

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_dig = 0; m_onlen = 0; m_pend = 0; m_fired = 0;
    for (int k = 0; k < 6; k++) begin m_act[k] = 8'h00; m_shd[k] = 8'h00; end
  endtask

  task automatic clr();
    done_seen = 0; pat_hits = 0; lit_any = 0;
    for (int k = 0; k < 6; k++) lit_seen[k] = 0;
  endtask

  // Expected pins after the coming edge, from the current state and inputs.
  task automatic model_step(output exp_t e);
    bit fe;
    if (m_cnt == 0) m_onlen = ((int'(i_bright) + 1) * (S - G)) >> 4;
    if (m_cnt >= G && m_cnt < G + m_onlen) begin
      e.enb = 6'h3f & ~(6'h01 << m_dig);
      e.seg = m_act[m_dig][6:0];
      e.dp  = m_act[m_dig][7];
    end else begin
      e.enb = 6'h3f; e.seg = 7'h00; e.dp = 1'b0;
    end
    fe      = (m_cnt == S - 1) && (m_dig == 5);
    e.done  = fe && m_pend;
    m_fired = i_wr_valid && !m_pend;
    if (m_fired && i_wr_addr < 3'd6) m_shd[i_wr_addr] = {i_wr_dp, i_wr_seg};
    if (fe && m_pend) begin
      m_act  = m_shd;
      m_pend = 0;
    end else if (i_commit) begin
      m_pend = 1;
    end
    e.rdy = !m_pend;
    if (m_cnt == S - 1) begin
      m_cnt = 0;
      m_dig = (m_dig == 5) ? 0 : m_dig + 1;
    end else begin
      m_cnt++;
    end
  endtask

  task automatic cycle();
    exp_t e, a;
    model_step(e);
    sb_q.push_back(e);
    @(negedge clk);
    a = {o_seg_enb, o_seg, o_seg_dp, o_wr_ready, o_commit_done};
    e = sb_q.pop_front();
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL pins t=%0t: got enb=%b seg=%b dp=%b rdy=%b done=%b, expected enb=%b seg=%b dp=%b rdy=%b done=%b",
               $time, a.enb, a.seg, a.dp, a.rdy, a.done, e.enb, e.seg, e.dp, e.rdy, e.done);
    end
    if (o_commit_done) done_seen++;
    if (o_seg_enb != 6'h3f) lit_any++;
    for (int k = 0; k < 6; k++) if (!o_seg_enb[k]) lit_seen[k]++;
    if ({o_seg_enb, o_seg, o_seg_dp} == {pat_enb, pat_seg, pat_dp}) pat_hits++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  // Advance until the model is about to process (dig, cnt); dig < 0 matches any digit.
  task automatic sync_to(input int dig, input int cnt);
    int guard;
    guard = 0;
    while (!((dig < 0 || m_dig == dig) && m_cnt == cnt) && guard < 500) begin
      cycle();
      guard++;
    end
    if (guard >= 500) begin
      checks++; errors++;
      $display("FAIL sync_timeout: got no slot position dig=%0d cnt=%0d, expected it within 500 cycles", dig, cnt);
    end
  endtask

  task automatic check_reset_pins(input string name);
    logic [15:0] got;
    got = {o_seg_enb, o_seg, o_seg_dp, o_wr_ready, o_commit_done};
    check(name, int'(got), int'(16'hFC02));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got no end of test, expected finish before 1000000 time units");
    $fatal(1);
  end

  initial begin
    row_t rows [6];
    int   guard;
    rows[0] = '{1'b1, 3'd2, 7'h7E, 1'b1, 1'b1, 4'd15, 1, 0};
    rows[1] = '{1'b0, 3'd0, 7'h00, 1'b0, 1'b0, 4'd15, 0, 32};
    rows[2] = '{1'b1, 3'd6, 7'h7F, 1'b1, 1'b0, 4'd3,  0, 8};
    rows[3] = '{1'b1, 3'd7, 7'h7F, 1'b1, 1'b1, 4'd3,  1, 8};
    rows[4] = '{1'b1, 3'd2, 7'h30, 1'b0, 1'b1, 4'd0,  1, 2};
    rows[5] = '{1'b0, 3'd0, 7'h00, 1'b0, 1'b0, 4'd0,  0, 0};

    // reset
    #1 rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_reset_pins("reset_pins");
    rst_n = 1'b1;
    model_reset();
    clr();
    pat_enb = 6'b111011; pat_seg = 7'h7E; pat_dp = 1'b1;

    // idle scan at brightness 0: each enable low for 2 cycles per frame
    run(240);
    for (int k = 0; k < 6; k++) check($sformatf("idle_enb_low_%0d", k), lit_seen[k], 2);

    // phase table, each row one frame-aligned frame
    for (int r = 0; r < 6; r++) begin
      sync_to(0, 0);
      clr();
      i_wr_valid = rows[r].wv; i_wr_addr = rows[r].addr; i_wr_seg = rows[r].seg;
      i_wr_dp = rows[r].dp; i_commit = rows[r].cm; i_bright = rows[r].br;
      cycle();
      i_wr_valid = 1'b0; i_commit = 1'b0;
      run(239);
      check($sformatf("row%0d_done", r), done_seen, rows[r].exp_done);
      check($sformatf("row%0d_dig2_hits", r), pat_hits, rows[r].exp_hits);
    end

    // brightness change mid-ON only affects the next slot
    i_bright = 4'd7;
    sync_to(-1, 1);
    sync_to(-1, 0);
    clr();
    run(20);
    i_bright = 4'd0;
    run(20);
    check("bright_cur_slot_on", lit_any, 16);
    clr();
    run(40);
    check("bright_next_slot_on", lit_any, 2);

    // writes held off while a commit is pending, landing after the copy
    sync_to(0, 0);
    i_wr_valid = 1'b1; i_wr_addr = 3'd0; i_wr_seg = 7'h06; i_wr_dp = 1'b0; i_commit = 1'b1;
    cycle();
    i_commit = 1'b0; i_wr_seg = 7'h5B;
    clr();
    guard = 0;
    do begin cycle(); guard++; end while (!m_fired && guard < 600);
    i_wr_valid = 1'b0;
    check("held_write_wait_bounded", int'(guard < 600), 1);
    check("held_write_done_before", done_seen, 1);
    pat_enb = 6'b111110; pat_seg = 7'h06; pat_dp = 1'b0;
    sync_to(0, 0);
    clr();
    run(240);
    check("held_write_old_visible", pat_hits, 2);
    pat_seg = 7'h5B;
    clr();
    run(240);
    check("held_write_not_yet_visible", pat_hits, 0);
    i_commit = 1'b1;
    cycle();
    i_commit = 1'b0;
    run(239);
    clr();
    run(240);
    check("held_write_visible_after_commit", pat_hits, 2);

    // two commit pulses in one frame give one done pulse
    sync_to(0, 0);
    clr();
    i_commit = 1'b1; cycle(); i_commit = 1'b0;
    run(50);
    i_commit = 1'b1; cycle(); i_commit = 1'b0;
    run(400);
    check("double_commit_done", done_seen, 1);

    // commit in the frame-end cycle waits for the following frame end
    sync_to(5, S - 1);
    clr();
    i_commit = 1'b1; cycle(); i_commit = 1'b0;
    run(239);
    check("fe_commit_not_yet", done_seen, 0);
    run(1);
    check("fe_commit_done", done_seen, 1);

    // reset mid-ON of digit 3 with a commit pending
    i_bright = 4'd15;
    sync_to(0, 0);
    i_commit = 1'b1; cycle(); i_commit = 1'b0;
    sync_to(3, G + 2);
    check("pre_reset_ready_low", int'(o_wr_ready), 0);
    rst_n = 1'b0;
    #1;
    check_reset_pins("async_reset_pins");
    @(negedge clk);
    check_reset_pins("held_reset_pins");
    rst_n = 1'b1;
    model_reset();
    clr();
    run(G + 1);
    check("restart_digit0_enb", int'(o_seg_enb), int'(6'b111110));
    run(480);
    check("no_done_after_reset", done_seen, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
